// File: rtl/irq_coalescing_controller_if.sv
// Bus bundle for irq_coalescing_controller.
// master: the side that supplies the sources, configuration and clear strobe,
//         and that observes pending/irq_id/event_count/IRQ.
// slave : the controller itself.
// Signals:
//   irq_src, edge_mode, irq_enable    per-source raw input, capture mode, enable
//   clr_valid, clr_mask               one-cycle write-1-to-clear strobe and mask
//   coal_thresh, coal_timeout         coalescing event threshold and timeout
//   pending, irq_id, event_count, IRQ controller status and interrupt output
interface irq_coalescing_controller_if #(
  parameter int NUM_SRC = 8,
  parameter int CNT_W   = 4,
  parameter int TMR_W   = 16
);
  localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] irq_src;
  logic [NUM_SRC-1:0] edge_mode;
  logic [NUM_SRC-1:0] irq_enable;
  logic               clr_valid;
  logic [NUM_SRC-1:0] clr_mask;
  logic [CNT_W-1:0]   coal_thresh;
  logic [TMR_W-1:0]   coal_timeout;
  logic [NUM_SRC-1:0] pending;
  logic [ID_W-1:0]    irq_id;
  logic [CNT_W-1:0]   event_count;
  logic               IRQ;

  modport master (
    output irq_src, edge_mode, irq_enable, clr_valid, clr_mask,
           coal_thresh, coal_timeout,
    input  pending, irq_id, event_count, IRQ
  );

  modport slave (
    input  irq_src, edge_mode, irq_enable, clr_valid, clr_mask,
           coal_thresh, coal_timeout,
    output pending, irq_id, event_count, IRQ
  );
endinterface

// File: rtl/irq_coalescing_controller.sv
// Interrupt coalescing controller.
// Captures NUM_SRC PCLK-synchronous sources (level or rising edge) into sticky
// pending bits, counts newly pending enabled bits, and raises a single
// registered IRQ once the event threshold or the timeout is reached. IRQ holds
// until no enabled pending bit remains.
// Ports:
//   PCLK    clock, rising edge
//   PRESET  synchronous active-high reset
//   bus     slave modport of irq_coalescing_controller_if (sources, config,
//           clear strobe in; pending, irq_id, event_count, IRQ out)
module irq_coalescing_controller #(
  parameter int NUM_SRC = 8,
  parameter int CNT_W   = 4,
  parameter int TMR_W   = 16
) (
  input  logic                         PCLK,
  input  logic                         PRESET,
  irq_coalescing_controller_if.slave   bus
);
  localparam int ID_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int PC_W  = $clog2(NUM_SRC + 1);
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COALESCE,
    ST_ASSERTED
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [NUM_SRC-1:0] r_pend, r_prev;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt, w_cnt_sat, w_thr;
  logic [TMR_W-1:0]   r_tmr, w_tmr_nxt;
  logic               r_irq;

  logic [NUM_SRC-1:0] w_set, w_pend_nxt, w_new_evt, w_act;
  logic [PC_W-1:0]    w_pop;
  logic [SUM_W-1:0]   w_sum;
  logic [ID_W-1:0]    w_id;
  logic               w_thr_hit, w_to_hit;

  // Capture, clear (set wins) and event detection.
  always_comb begin
    w_set      = (bus.irq_src & ~r_prev & bus.edge_mode) |
                 (bus.irq_src & ~bus.edge_mode);
    w_pend_nxt = w_set | (r_pend & ~({NUM_SRC{bus.clr_valid}} & bus.clr_mask));
    w_new_evt  = w_pend_nxt & ~r_pend & bus.irq_enable;
    w_act      = r_pend & bus.irq_enable;
  end

  // Saturating accumulation of the events seen this cycle.
  always_comb begin
    w_pop = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++)
      w_pop = w_pop + PC_W'(w_new_evt[i]);
    w_sum     = SUM_W'(r_cnt) + SUM_W'(w_pop);
    w_cnt_sat = (w_sum > SUM_W'({CNT_W{1'b1}})) ? '1 : w_sum[CNT_W-1:0];
  end

  // Lowest enabled pending index; scanning downwards leaves the lowest hit.
  always_comb begin
    w_id = '0;
    for (int unsigned i = NUM_SRC; i > 0; i--)
      if (w_act[i-1]) w_id = ID_W'(i - 1);
  end

  always_comb begin
    w_thr     = (bus.coal_thresh == '0) ? CNT_W'(1) : bus.coal_thresh;
    w_thr_hit = (r_cnt >= w_thr);
    w_to_hit  = (bus.coal_timeout != '0) &&
                (r_tmr == bus.coal_timeout - TMR_W'(1));
  end

  // Next-state and window counters. IDLE looks at the pending value being
  // written this edge so a fresh event opens the window on the same edge;
  // the other states use the registered pending bits.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_cnt_sat;
    w_tmr_nxt   = r_tmr;
    case (r_state)
      ST_IDLE: begin
        if (|(w_pend_nxt & bus.irq_enable)) begin
          w_state_nxt = ST_COALESCE;
          w_tmr_nxt   = '0;
        end
      end
      ST_COALESCE: begin
        if (w_thr_hit || w_to_hit) begin
          w_state_nxt = ST_ASSERTED;
        end else if (w_act == '0) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_tmr_nxt   = '0;
        end else if (r_tmr != '1) begin
          w_tmr_nxt = r_tmr + TMR_W'(1);
        end
      end
      ST_ASSERTED: begin
        if (w_act == '0) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_tmr_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        w_tmr_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state <= ST_IDLE;
      r_pend  <= '0;
      r_prev  <= '0;
      r_cnt   <= '0;
      r_tmr   <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_prev  <= bus.irq_src;
      r_cnt   <= w_cnt_nxt;
      r_tmr   <= w_tmr_nxt;
      r_irq   <= (w_state_nxt == ST_ASSERTED);
    end
  end

  assign bus.pending     = r_pend;
  assign bus.irq_id      = w_id;
  assign bus.event_count = r_cnt;
  assign bus.IRQ         = r_irq;
endmodule

// File: tb/tb_irq_coalescing_controller.sv
// Self-checking bench for irq_coalescing_controller (NUM_SRC=8, CNT_W=4,
// TMR_W=16). Each vector holds one cycle of inputs plus the outputs expected
// after the following rising edge.
module tb_irq_coalescing_controller;
  logic PCLK = 1'b0;
  logic PRESET;

  irq_coalescing_controller_if #(.NUM_SRC(8), .CNT_W(4), .TMR_W(16)) bus ();

  irq_coalescing_controller #(.NUM_SRC(8), .CNT_W(4), .TMR_W(16)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    string       name;
    logic        rst;
    logic [7:0]  src;
    logic [7:0]  em;
    logic [7:0]  en;
    logic        cv;
    logic [7:0]  cm;
    logic [3:0]  th;
    logic [15:0] to;
    logic [7:0]  ep;
    logic [2:0]  eid;
    logic [3:0]  ec;
    logic        eirq;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic vec_t V(string n, logic rst, logic [7:0] src, logic [7:0] em,
                             logic [7:0] en, logic cv, logic [7:0] cm,
                             logic [3:0] th, logic [15:0] to, logic [7:0] ep,
                             logic [2:0] eid, logic [3:0] ec, logic eirq);
    vec_t v;
    v.name = n; v.rst = rst; v.src = src; v.em = em; v.en = en; v.cv = cv;
    v.cm = cm; v.th = th; v.to = to; v.ep = ep; v.eid = eid; v.ec = ec;
    v.eirq = eirq;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    vec_t e;
    PRESET           = v.rst;
    bus.irq_src      = v.src;
    bus.edge_mode    = v.em;
    bus.irq_enable   = v.en;
    bus.clr_valid    = v.cv;
    bus.clr_mask     = v.cm;
    bus.coal_thresh  = v.th;
    bus.coal_timeout = v.to;
    exp_q.push_back(v);
    @(posedge PCLK);
    #1;
    e = exp_q.pop_front();
    n_vec++;
    if (bus.pending !== e.ep || bus.irq_id !== e.eid ||
        bus.event_count !== e.ec || bus.IRQ !== e.eirq) begin
      n_miss++;
      $display("FAIL %s: got pend=%h id=%0d cnt=%0d irq=%b, expected pend=%h id=%0d cnt=%0d irq=%b",
               e.name, bus.pending, bus.irq_id, bus.event_count, bus.IRQ,
               e.ep, e.eid, e.ec, e.eirq);
    end
  endtask

  initial begin
    //            name        rst src    em     en     cv cm     th  to     ep     id cnt irq
    // Basic edge capture, thresh 0 behaves as 1, clear timing.
    tbl.push_back(V("rst0",     1, 8'h00, 8'hFF, 8'hFF, 0, 8'h00, 0, 16'd0, 8'h00, 0, 0, 0));
    tbl.push_back(V("rst1",     1, 8'h00, 8'hFF, 8'hFF, 0, 8'h00, 0, 16'd0, 8'h00, 0, 0, 0));
    tbl.push_back(V("idle",     0, 8'h00, 8'hFF, 8'hFF, 0, 8'h00, 0, 16'd0, 8'h00, 0, 0, 0));
    tbl.push_back(V("s3_edge",  0, 8'h08, 8'hFF, 8'hFF, 0, 8'h00, 0, 16'd0, 8'h08, 3, 1, 0));
    tbl.push_back(V("s3_irq",   0, 8'h00, 8'hFF, 8'hFF, 0, 8'h00, 0, 16'd0, 8'h08, 3, 1, 1));
    tbl.push_back(V("s3_hold",  0, 8'h00, 8'hFF, 8'hFF, 0, 8'h00, 0, 16'd0, 8'h08, 3, 1, 1));
    tbl.push_back(V("s3_clr",   0, 8'h00, 8'hFF, 8'hFF, 1, 8'h08, 0, 16'd0, 8'h00, 0, 1, 1));
    tbl.push_back(V("s3_fall",  0, 8'h00, 8'hFF, 8'hFF, 0, 8'h00, 0, 16'd0, 8'h00, 0, 0, 0));
    // Threshold 4: two simultaneous events then two more.
    tbl.push_back(V("th_ev2",   0, 8'h03, 8'hFF, 8'hFF, 0, 8'h00, 4, 16'd0, 8'h03, 0, 2, 0));
    tbl.push_back(V("th_wait",  0, 8'h00, 8'hFF, 8'hFF, 0, 8'h00, 4, 16'd0, 8'h03, 0, 2, 0));
    tbl.push_back(V("th_ev4",   0, 8'h24, 8'hFF, 8'hFF, 0, 8'h00, 4, 16'd0, 8'h27, 0, 4, 0));
    tbl.push_back(V("th_irq",   0, 8'h00, 8'hFF, 8'hFF, 0, 8'h00, 4, 16'd0, 8'h27, 0, 4, 1));
    tbl.push_back(V("th_clr",   0, 8'h00, 8'hFF, 8'hFF, 1, 8'hFF, 4, 16'd0, 8'h00, 0, 4, 1));
    tbl.push_back(V("th_fall",  0, 8'h00, 8'hFF, 8'hFF, 0, 8'h00, 4, 16'd0, 8'h00, 0, 0, 0));
    // Counter saturation at 15 with threshold 15.
    tbl.push_back(V("sat_8",    0, 8'hFF, 8'hFF, 8'hFF, 0, 8'h00, 15, 16'd0, 8'hFF, 0, 8, 0));
    tbl.push_back(V("sat_c1",   0, 8'h00, 8'hFF, 8'hFF, 1, 8'h0F, 15, 16'd0, 8'hF0, 4, 8, 0));
    tbl.push_back(V("sat_12",   0, 8'h0F, 8'hFF, 8'hFF, 0, 8'h00, 15, 16'd0, 8'hFF, 0, 12, 0));
    tbl.push_back(V("sat_c2",   0, 8'h00, 8'hFF, 8'hFF, 1, 8'h0F, 15, 16'd0, 8'hF0, 4, 12, 0));
    tbl.push_back(V("sat_15",   0, 8'h0F, 8'hFF, 8'hFF, 0, 8'h00, 15, 16'd0, 8'hFF, 0, 15, 0));
    tbl.push_back(V("sat_irq",  0, 8'h00, 8'hFF, 8'hFF, 0, 8'h00, 15, 16'd0, 8'hFF, 0, 15, 1));
    tbl.push_back(V("sat_clr",  0, 8'h00, 8'hFF, 8'hFF, 1, 8'hFF, 15, 16'd0, 8'h00, 0, 15, 1));
    tbl.push_back(V("sat_fall", 0, 8'h00, 8'hFF, 8'hFF, 0, 8'h00, 15, 16'd0, 8'h00, 0, 0, 0));
    // Level source 6: set wins over clear while the source is high.
    tbl.push_back(V("lv_set",   0, 8'h40, 8'hBF, 8'hFF, 0, 8'h00, 1, 16'd0, 8'h40, 6, 1, 0));
    tbl.push_back(V("lv_irq",   0, 8'h40, 8'hBF, 8'hFF, 0, 8'h00, 1, 16'd0, 8'h40, 6, 1, 1));
    tbl.push_back(V("lv_clrhi", 0, 8'h40, 8'hBF, 8'hFF, 1, 8'h40, 1, 16'd0, 8'h40, 6, 1, 1));
    tbl.push_back(V("lv_hold",  0, 8'h40, 8'hBF, 8'hFF, 0, 8'h00, 1, 16'd0, 8'h40, 6, 1, 1));
    tbl.push_back(V("lv_drop",  0, 8'h00, 8'hBF, 8'hFF, 0, 8'h00, 1, 16'd0, 8'h40, 6, 1, 1));
    tbl.push_back(V("lv_clr",   0, 8'h00, 8'hBF, 8'hFF, 1, 8'h40, 1, 16'd0, 8'h00, 0, 1, 1));
    tbl.push_back(V("lv_fall",  0, 8'h00, 8'hBF, 8'hFF, 0, 8'h00, 1, 16'd0, 8'h00, 0, 0, 0));
    // Disabled source 2 latches silently; enabling it opens a window (timeout 1).
    tbl.push_back(V("dis_set",  0, 8'h04, 8'hFF, 8'hFB, 0, 8'h00, 1, 16'd1, 8'h04, 0, 0, 0));
    tbl.push_back(V("dis_hold", 0, 8'h00, 8'hFF, 8'hFB, 0, 8'h00, 1, 16'd1, 8'h04, 0, 0, 0));
    tbl.push_back(V("en_open",  0, 8'h00, 8'hFF, 8'hFF, 0, 8'h00, 1, 16'd1, 8'h04, 2, 0, 0));
    tbl.push_back(V("en_irq",   0, 8'h00, 8'hFF, 8'hFF, 0, 8'h00, 1, 16'd1, 8'h04, 2, 0, 1));
    tbl.push_back(V("mask_off", 0, 8'h00, 8'hFF, 8'hFB, 0, 8'h00, 1, 16'd1, 8'h04, 0, 0, 0));
    tbl.push_back(V("unm_open", 0, 8'h00, 8'hFF, 8'hFF, 0, 8'h00, 1, 16'd1, 8'h04, 2, 0, 0));
    tbl.push_back(V("unm_irq",  0, 8'h00, 8'hFF, 8'hFF, 0, 8'h00, 1, 16'd1, 8'h04, 2, 0, 1));
    tbl.push_back(V("unm_clr",  0, 8'h00, 8'hFF, 8'hFF, 1, 8'h04, 1, 16'd1, 8'h00, 0, 0, 1));
    tbl.push_back(V("unm_fall", 0, 8'h00, 8'hFF, 8'hFF, 0, 8'h00, 1, 16'd1, 8'h00, 0, 0, 0));
    // Edge source held through reset gives exactly one event; reset mid-window.
    tbl.push_back(V("hr_rst0",  1, 8'h10, 8'hFF, 8'hFF, 0, 8'h00, 1, 16'd0, 8'h00, 0, 0, 0));
    tbl.push_back(V("hr_rst1",  1, 8'h10, 8'hFF, 8'hFF, 0, 8'h00, 1, 16'd0, 8'h00, 0, 0, 0));
    tbl.push_back(V("hr_ev",    0, 8'h10, 8'hFF, 8'hFF, 0, 8'h00, 1, 16'd0, 8'h10, 4, 1, 0));
    tbl.push_back(V("hr_irq",   0, 8'h10, 8'hFF, 8'hFF, 0, 8'h00, 1, 16'd0, 8'h10, 4, 1, 1));
    tbl.push_back(V("hr_once",  0, 8'h10, 8'hFF, 8'hFF, 0, 8'h00, 1, 16'd0, 8'h10, 4, 1, 1));
    tbl.push_back(V("hr_clr",   0, 8'h10, 8'hFF, 8'hFF, 1, 8'h10, 1, 16'd0, 8'h00, 0, 1, 1));
    tbl.push_back(V("hr_fall",  0, 8'h10, 8'hFF, 8'hFF, 0, 8'h00, 1, 16'd0, 8'h00, 0, 0, 0));
    tbl.push_back(V("mw_idle",  0, 8'h00, 8'hFF, 8'hFF, 0, 8'h00, 4, 16'd0, 8'h00, 0, 0, 0));
    tbl.push_back(V("mw_coal",  0, 8'h01, 8'hFF, 8'hFF, 0, 8'h00, 4, 16'd0, 8'h01, 0, 1, 0));
    tbl.push_back(V("mw_rst",   1, 8'h00, 8'hFF, 8'hFF, 0, 8'h00, 4, 16'd0, 8'h00, 0, 0, 0));
    tbl.push_back(V("mw_after", 0, 8'h00, 8'hFF, 8'hFF, 0, 8'h00, 4, 16'd0, 8'h00, 0, 0, 0));

    foreach (tbl[i]) apply(tbl[i]);

    // Timeout 10 with threshold 15: a single event forces IRQ ten edges later.
    apply(V("to_ev", 0, 8'h01, 8'hFF, 8'hFF, 0, 8'h00, 15, 16'd10, 8'h01, 0, 1, 0));
    for (int j = 1; j < 10; j++)
      apply(V("to_wait", 0, 8'h00, 8'hFF, 8'hFF, 0, 8'h00, 15, 16'd10, 8'h01, 0, 1, 0));
    apply(V("to_irq",  0, 8'h00, 8'hFF, 8'hFF, 0, 8'h00, 15, 16'd10, 8'h01, 0, 1, 1));
    apply(V("to_clr",  0, 8'h00, 8'hFF, 8'hFF, 1, 8'h01, 15, 16'd10, 8'h00, 0, 1, 1));
    apply(V("to_fall", 0, 8'h00, 8'hFF, 8'hFF, 0, 8'h00, 15, 16'd10, 8'h00, 0, 0, 0));
    n_vec++;
    if (dut.r_tmr !== 16'd0) begin
      n_miss++;
      $display("FAIL to_timer: got timer=%0d, expected timer=0", dut.r_tmr);
    end

    // Timeout 1 behaves as immediate even with a high threshold.
    apply(V("to1_ev",  0, 8'h02, 8'hFF, 8'hFF, 0, 8'h00, 15, 16'd1, 8'h02, 1, 1, 0));
    apply(V("to1_irq", 0, 8'h00, 8'hFF, 8'hFF, 0, 8'h00, 15, 16'd1, 8'h02, 1, 1, 1));
    apply(V("to1_clr", 0, 8'h00, 8'hFF, 8'hFF, 1, 8'h02, 15, 16'd1, 8'h00, 0, 1, 1));
    apply(V("to1_end", 0, 8'h00, 8'hFF, 8'hFF, 0, 8'h00, 15, 16'd1, 8'h00, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
